// File: rtl/vecmat_sched_pkg.sv
// vecmat_sched_pkg: shared attention-layer types and sizing constants
package vecmat_sched_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int DATA_WIDTH        = 16;
  localparam int LANES             = 64;
  localparam int NUM_WORDS_DEFAULT = 32;

endpackage

// File: rtl/vecmat_out_fifo.sv
// vecmat_out_fifo: show-ahead FIFO with occupancy count; DEPTH must be a power of two
module vecmat_out_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         valid,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;

  // Storage is not reset; the head is gated to zero while empty instead
  always_ff @(posedge clk)
    if (wr_en) mem[wptr] <= wr_data;

  // Pointers wrap naturally; a simultaneous push and pop keeps count unchanged
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
      count <= count + CW'(wr_en) - CW'(rd_en);
    end

  assign valid   = count != '0;
  assign rd_data = valid ? mem[rptr] : '0;

endmodule

// File: rtl/vecmat_sched.sv
// vecmat_sched: credit-gated K-row streamer feeding vecmat_mul; VECMAT_SCHED_MASK_EN adds row masking
module vecmat_sched
  import vecmat_sched_pkg::*;
#(
  parameter int ARRAYSIZE  = DATA_WIDTH * LANES,
  parameter int NUM_WORDS  = NUM_WORDS_DEFAULT,
  parameter int ADDR_W     = 5,
  parameter int RD_LAT     = 1,
  parameter int MUL_LAT    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ARRAYSIZE-1:0] q_vector,
`ifdef VECMAT_SCHED_MASK_EN
  input  logic [ADDR_W:0]      mask_len,
`endif
  output logic                 busy,
  output logic                 done,
  output logic                 k_rd_en,
  output logic [ADDR_W-1:0]    k_rd_addr,
  input  logic [ARRAYSIZE-1:0] k_rd_data,
  output logic [ARRAYSIZE-1:0] mul_vector,
  output logic [ARRAYSIZE-1:0] mul_matrix,
  input  logic [ARRAYSIZE-1:0] mul_result,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ADDR_W-1:0]    out_addr,
  output logic [ARRAYSIZE-1:0] out_data
);

  localparam int LAT = RD_LAT + MUL_LAT;
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W:0] NW      = (ADDR_W + 1)'(NUM_WORDS);
  localparam logic [CW:0]     DEPTH_C = (CW + 1)'(FIFO_DEPTH);

  state_t                     state, state_nx;
  logic [ARRAYSIZE-1:0]       q_reg;
  logic [ADDR_W:0]            issued, accepted;
  logic [LAT-1:0]             sr_vld, sr_msk;
  logic [LAT-1:0][ADDR_W-1:0] sr_addr;
  logic [CW-1:0]              inflight, fifo_count;
  logic                       issue, live, credit, rd;
  logic [ARRAYSIZE-1:0]       product;

`ifdef VECMAT_SCHED_MASK_EN
  logic [ADDR_W:0] mask_reg;

  // Mask length is frozen for the whole pass at the accepted start
  always_ff @(posedge clk or negedge reset)
    if (!reset) mask_reg <= '0;
    else if (state == IDLE && start) mask_reg <= mask_len;

  assign live = issued < mask_reg;
`else
  assign live = 1'b1;
`endif

  // Rows issued but not yet written into the FIFO are exactly the valid pipeline stages
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) inflight = inflight + CW'(sr_vld[i]);
  end

  assign credit = ({1'b0, inflight} + {1'b0, fifo_count}) < DEPTH_C;
  assign rd     = out_valid && out_ready;

  // State register, pass counters, query latch and the issue-tracking shift register
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state    <= IDLE;
      q_reg    <= '0;
      issued   <= '0;
      accepted <= '0;
      sr_vld   <= '0;
      sr_msk   <= '0;
      sr_addr  <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        q_reg    <= q_vector;
        issued   <= '0;
        accepted <= '0;
      end else begin
        if (issue) issued <= issued + 1'b1;
        if (rd) accepted <= accepted + 1'b1;
      end
      sr_vld[0]  <= issue;
      sr_msk[0]  <= !live;
      sr_addr[0] <= issued[ADDR_W-1:0];
      for (int i = 1; i < LAT; i++) begin
        sr_vld[i]  <= sr_vld[i-1];
        sr_msk[i]  <= sr_msk[i-1];
        sr_addr[i] <= sr_addr[i-1];
      end
    end

  // Next state and per-state strobes; DONE is entered on the cycle the last row is accepted
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    issue    = 1'b0;
    unique case (state)
      IDLE:  state_nx = start ? RUN : IDLE;
      RUN: begin
        busy     = 1'b1;
        issue    = (issued != NW) && credit;
        state_nx = (issued == NW) ? DRAIN : RUN;
      end
      DRAIN: begin
        busy     = 1'b1;
        state_nx = (accepted + (ADDR_W + 1)'(rd) == NW) ? DONE : DRAIN;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
    endcase
  end

  assign k_rd_en    = issue && live;
  assign k_rd_addr  = issued[ADDR_W-1:0];
  assign mul_vector = q_reg;
  assign mul_matrix = k_rd_data;
  assign product    = sr_msk[LAT-1] ? '0 : mul_result;

  vecmat_out_fifo #(
    .W     (ADDR_W + ARRAYSIZE),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (sr_vld[LAT-1]),
    .wr_data ({sr_addr[LAT-1], product}),
    .rd_en   (rd),
    .rd_data ({out_addr, out_data}),
    .valid   (out_valid),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_vecmat_sched.sv
// tb_vecmat_sched: directed and random-backpressure bench with K-RAM and multiplier models
module tb_vecmat_sched;
  import vecmat_sched_pkg::*;

  localparam int AS = 1024;
  localparam int NW = 32;
  localparam int AW = 5;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [AS-1:0] d;
  } exp_t;

  logic          clk = 1'b0, reset = 1'b0, start = 1'b0, out_ready = 1'b1;
  logic [AS-1:0] q_vector = '0, k_rd_data = '0, mul_result = '0;
  logic          busy, done, k_rd_en, out_valid;
  logic [AW-1:0] k_rd_addr, out_addr;
  logic [AS-1:0] mul_vector, mul_matrix, out_data;
`ifdef VECMAT_SCHED_MASK_EN
  logic [AW:0]   mask_len = '0;
`endif

  exp_t          sb[$];
  int            checks = 0, errors = 0, cyc = 0, out_cnt = 0, rd_cnt = 0;
  logic [15:0]   salt = '0;
  logic [AS-1:0] q1, q2;

  always #5 clk = ~clk;

  vecmat_sched dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .q_vector   (q_vector),
`ifdef VECMAT_SCHED_MASK_EN
    .mask_len   (mask_len),
`endif
    .busy       (busy),
    .done       (done),
    .k_rd_en    (k_rd_en),
    .k_rd_addr  (k_rd_addr),
    .k_rd_data  (k_rd_data),
    .mul_vector (mul_vector),
    .mul_matrix (mul_matrix),
    .mul_result (mul_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_data   (out_data)
  );

  function automatic logic [AS-1:0] row(int i);
    logic [AS-1:0] r;
    for (int l = 0; l < 64; l++) r[l*16 +: 16] = 16'(i) + 16'(l) * salt;
    return r;
  endfunction

  function automatic logic [AS-1:0] mul(logic [AS-1:0] v, logic [AS-1:0] m);
    logic [AS-1:0] r;
    logic signed [31:0] p;
    for (int l = 0; l < 64; l++) begin
      p = $signed(v[l*16 +: 16]) * $signed(m[l*16 +: 16]);
      r[l*16 +: 16] = p[15:0];
    end
    return r;
  endfunction

  function automatic logic [AS-1:0] rnd_vec();
    logic [AS-1:0] r;
    for (int i = 0; i < AS / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic int first_diff(logic [AS-1:0] a, logic [AS-1:0] b);
    for (int l = 0; l < 64; l++) if (a[l*16 +: 16] !== b[l*16 +: 16]) return l;
    return 0;
  endfunction

  // K RAM with one-cycle read latency
  always @(posedge clk) if (k_rd_en) k_rd_data <= row(int'(k_rd_addr));

  // Free-running multiplier with one-cycle latency
  always @(posedge clk) mul_result <= mul(mul_vector, mul_matrix);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [AS-1:0] obs, input logic [AS-1:0] exp);
    int l;
    checks++;
    l = first_diff(obs, exp);
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: lane %0d observed %h expected %h", tag, l, obs[l*16 +: 16], exp[l*16 +: 16]);
    end
  endtask

  // Scoreboard pop on every accepted output, occupancy bound and read-strobe count
  always @(negedge clk) if (reset) begin
    checks++;
    assert (dut.fifo_count <= 4) else begin
      errors++;
      $error("FAIL fifo_count: observed %0d expected <= 4", dut.fifo_count);
    end
    if (k_rd_en) rd_cnt++;
    if (out_valid && out_ready) begin
      out_cnt++;
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL extra_output: observed row %0d expected no output", out_addr);
      end
      if (sb.size() != 0) begin : pop
        exp_t e;
        e = sb.pop_front();
        chk("out_addr", 64'(out_addr), 64'(e.a));
        chkv("out_data", out_data, e.d);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic begin_pass(input logic [AS-1:0] q, input int mlen);
    exp_t e;
    for (int i = 0; i < NW; i++) begin
      e.a = AW'(i);
      e.d = (i < mlen) ? mul(q, row(i)) : '0;
      sb.push_back(e);
    end
`ifdef VECMAT_SCHED_MASK_EN
    mask_len = (AW + 1)'(mlen);
`endif
    q_vector = q;
    start    = 1'b1;
    cyc      = 0;
    out_cnt  = 0;
    rd_cnt   = 0;
    tick();
    start    = 1'b0;
    q_vector = ~q;
  endtask

  task automatic wait_done(input bit rnd);
    int n = 0;
    while (done !== 1'b1 && n < 3000) begin
      if (rnd) out_ready = $urandom_range(99) < 30;
      tick();
      n++;
    end
    chk("done_seen", 64'(done), 64'd1);
    chk("busy_at_done", 64'(busy), 64'd0);
    out_ready = 1'b1;
  endtask

  task automatic end_pass(input int reads);
    chk("out_count", 64'(out_cnt), 64'd32);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    chk("rd_pulses", 64'(rd_cnt), 64'(reads));
    tick();
    chk("done_one_cycle", 64'(done), 64'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_k_rd_en"}, 64'(k_rd_en), 64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_k_rd_addr"}, 64'(k_rd_addr), 64'd0);
    chk({tag, "_out_addr"}, 64'(out_addr), 64'd0);
    chkv({tag, "_out_data"}, out_data, '0);
    chkv({tag, "_mul_vector"}, mul_vector, '0);
    chk({tag, "_state"}, 64'(dut.state), 64'(IDLE));
  endtask

  initial begin
    #1;
    chk_zero("reset");
    tick();
    reset = 1'b1;
    tick();
    tick();

    // Full pass, ready high: q lanes 0x0100, row i lanes = i
    for (int l = 0; l < 64; l++) q1[l*16 +: 16] = 16'h0100;
    begin_pass(q1, NW);
    chk("c1_busy", 64'(busy), 64'd1);
    chk("c1_k_rd_en", 64'(k_rd_en), 64'd1);
    chk("c1_k_rd_addr", 64'(k_rd_addr), 64'd0);
    tick();
    tick();
    chk("c3_out_valid", 64'(out_valid), 64'd0);
    tick();
    chk("c4_out_valid", 64'(out_valid), 64'd1);
    chk("c4_out_addr", 64'(out_addr), 64'd0);
    wait_done(1'b0);
    chk("done_cycle", 64'(cyc), 64'd36);
    end_pass(NW);

    // Backpressure in cycles 4..20 stops issue at four outstanding rows
    salt = 16'd7;
    q2 = rnd_vec();
    begin_pass(q2, NW);
    while (cyc < 4) tick();
    out_ready = 1'b0;
    while (cyc < 20) tick();
    chk("stall_rd_pulses", 64'(rd_cnt), 64'd4);
    chk("stall_k_rd_en", 64'(k_rd_en), 64'd0);
    chk("stall_fifo_count", 64'(dut.fifo_count), 64'd4);
    chk("stall_out_valid", 64'(out_valid), 64'd1);
    chk("stall_out_addr", 64'(out_addr), 64'd0);
    chkv("stall_out_data", out_data, mul(q2, row(0)));
    tick();
    out_ready = 1'b1;
    wait_done(1'b0);
    end_pass(NW);

    // Random 30% ready duty over 20 passes
    for (int p = 0; p < 20; p++) begin
      salt = 16'($urandom);
      begin_pass(rnd_vec(), NW);
      wait_done(1'b1);
      end_pass(NW);
    end

    // Start pulse mid-pass is ignored and the captured query holds
    salt = 16'd3;
    q2 = rnd_vec();
    begin_pass(q2, NW);
    while (cyc < 10) tick();
    start = 1'b1;
    q_vector = rnd_vec();
    tick();
    start = 1'b0;
    chkv("restart_q_reg", mul_vector, q2);
    chk("restart_busy", 64'(busy), 64'd1);
    wait_done(1'b0);
    end_pass(NW);

    // Asynchronous reset in cycle 15 clears everything, then a clean pass
    begin_pass(rnd_vec(), NW);
    while (cyc < 15) tick();
    reset = 1'b0;
    #1;
    chk_zero("midreset");
    sb.delete();
    tick();
    tick();
    reset = 1'b1;
    tick();
    salt = 16'd11;
    begin_pass(rnd_vec(), NW);
    wait_done(1'b0);
    chk("post_reset_done_cycle", 64'(cyc), 64'd36);
    end_pass(NW);

`ifdef VECMAT_SCHED_MASK_EN
    // Masked pass: only rows 0..9 read, the rest emitted as zeros
    salt = 16'd5;
    begin_pass(rnd_vec(), 10);
    wait_done(1'b0);
    chk("mask_done_cycle", 64'(cyc), 64'd36);
    end_pass(10);
    begin_pass(rnd_vec(), 0);
    wait_done(1'b0);
    end_pass(0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
